// File: rtl/buttons_pkg.sv
// Shared constants and helpers for the button event controller.
package buttons_pkg;

    localparam int unsigned SYNC_STAGES              = 2;
    localparam int unsigned DEFAULT_CHANNELS         = 4;
    localparam int unsigned DEFAULT_DEBOUNCING_TICKS = 4;
    localparam int unsigned DEFAULT_LONG_PRESS_TICKS = 1000;

    // Bits needed to hold a count from 0 up to and including n.
    function automatic int unsigned counter_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, debounce, edge pulses, pending flag.
// Optional long-press detection is built when BUTTONS_LONG_PRESS_EN is defined.
module button_channel
    import buttons_pkg::*;
#(
    parameter int unsigned DEBOUNCING_TICKS = DEFAULT_DEBOUNCING_TICKS
`ifdef BUTTONS_LONG_PRESS_EN
    ,
    parameter int unsigned LONG_PRESS_TICKS = DEFAULT_LONG_PRESS_TICKS
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_pin,
    input  logic ack,
    output logic pressed,
    output logic press_event,
    output logic release_event,
    output logic pending
`ifdef BUTTONS_LONG_PRESS_EN
    ,
    output logic long_press
`endif
);

    localparam int unsigned DW = counter_width(DEBOUNCING_TICKS);

    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0]          db_cnt;
    logic                   synced_c;
    logic                   toggle_c;
    logic                   set_c;

    assign synced_c = sync[SYNC_STAGES-1];
    // Level has disagreed with pressed for the full debounce window on this edge.
    assign toggle_c = (synced_c != pressed) && (db_cnt == DW'(DEBOUNCING_TICKS - 1));

    // Invert the active-low pin and bring it into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], ~button_pin};
        end
    end

    // Debounce counter, accepted level and registered edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt        <= '0;
            pressed       <= 1'b0;
            press_event   <= 1'b0;
            release_event <= 1'b0;
        end else begin
            press_event   <= toggle_c & ~pressed;
            release_event <= toggle_c & pressed;
            if ((synced_c == pressed) || toggle_c) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
            if (toggle_c) begin
                pressed <= ~pressed;
            end
        end
    end

`ifdef BUTTONS_LONG_PRESS_EN
    localparam int unsigned HW = counter_width(LONG_PRESS_TICKS);

    logic [HW-1:0] hold_cnt;

    // Hold counter saturates, so the long-press pulse fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= pressed && (hold_cnt == HW'(LONG_PRESS_TICKS - 1));
            if (!pressed) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HW'(LONG_PRESS_TICKS)) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    assign set_c = press_event | long_press;
`else
    assign set_c = press_event;
`endif

    // Sticky pending flag; a new event wins over a coincident ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (set_c) begin
            pending <= 1'b1;
        end else if (ack) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/buttons_event_controller.sv
// Multi-channel debounced button controller with per-channel pending flags
// and a masked interrupt. Long-press support: define BUTTONS_LONG_PRESS_EN.
module buttons_event_controller
    import buttons_pkg::*;
#(
    parameter int unsigned CHANNELS         = DEFAULT_CHANNELS,
    parameter int unsigned DEBOUNCING_TICKS = DEFAULT_DEBOUNCING_TICKS,
    parameter int unsigned LONG_PRESS_TICKS = DEFAULT_LONG_PRESS_TICKS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] button_pins,
    input  logic [CHANNELS-1:0] ack,
    input  logic [CHANNELS-1:0] irq_mask,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] press_event,
    output logic [CHANNELS-1:0] release_event,
    output logic [CHANNELS-1:0] pending,
    output logic                irq
`ifdef BUTTONS_LONG_PRESS_EN
    ,
    output logic [CHANNELS-1:0] long_press
`endif
);

    // Reject illegal configurations at elaboration.
    if ((CHANNELS < 1) || (CHANNELS > 32) || (DEBOUNCING_TICKS < 1) || (LONG_PRESS_TICKS < 1)) begin : g_bad_params
        $error("buttons_event_controller: illegal parameter value");
    end

    // One independent channel per button.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCING_TICKS (DEBOUNCING_TICKS)
`ifdef BUTTONS_LONG_PRESS_EN
            ,
            .LONG_PRESS_TICKS (LONG_PRESS_TICKS)
`endif
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .button_pin    (button_pins[i]),
            .ack           (ack[i]),
            .pressed       (pressed[i]),
            .press_event   (press_event[i]),
            .release_event (release_event[i]),
            .pending       (pending[i])
`ifdef BUTTONS_LONG_PRESS_EN
            ,
            .long_press    (long_press[i])
`endif
        );
    end

    // Interrupt follows the mask input directly, no added latency.
    assign irq = |(pending & irq_mask);

endmodule

// File: tb/tb_buttons_event_controller.sv
// Self-checking bench for buttons_event_controller: directed scenarios plus
// randomized pin/ack/mask traffic against a behavioural model.
module tb_buttons_event_controller;

    localparam int CH  = 4;
    localparam int DT  = 4;
    localparam int LPT = 16;
`ifdef BUTTONS_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] button_pins;
    logic [CH-1:0] ack;
    logic [CH-1:0] irq_mask;
    logic [CH-1:0] pressed;
    logic [CH-1:0] press_event;
    logic [CH-1:0] release_event;
    logic [CH-1:0] pending;
    logic          irq;
`ifdef BUTTONS_LONG_PRESS_EN
    logic [CH-1:0] long_press;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    buttons_event_controller #(
        .CHANNELS         (CH),
        .DEBOUNCING_TICKS (DT),
        .LONG_PRESS_TICKS (LPT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .button_pins   (button_pins),
        .ack           (ack),
        .irq_mask      (irq_mask),
        .pressed       (pressed),
        .press_event   (press_event),
        .release_event (release_event),
        .pending       (pending),
        .irq           (irq)
`ifdef BUTTONS_LONG_PRESS_EN
        ,
        .long_press    (long_press)
`endif
    );

    // Behavioural model: a level is accepted once the synchronised pin has
    // disagreed with the accepted level for DT samples in a row.
    logic [CH-1:0] m_s1 = '0, m_s2 = '0;
    logic [CH-1:0] m_pressed = '0, m_pe = '0, m_re = '0, m_pend = '0, m_lp = '0;
    bit            m_hist [CH][DT];
    int            m_hold [CH];
    bit            all_differ;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0;
            m_pressed = '0; m_pe = '0; m_re = '0; m_pend = '0; m_lp = '0;
            for (int i = 0; i < CH; i++) begin
                m_hold[i] = 0;
                for (int k = 0; k < DT; k++) m_hist[i][k] = 1'b0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (m_pe[i] || (LP_EN && m_lp[i])) m_pend[i] = 1'b1;
                else if (ack[i])                    m_pend[i] = 1'b0;
                m_hold[i] = m_pressed[i] ? m_hold[i] + 1 : 0;
                m_lp[i]   = m_pressed[i] && (m_hold[i] == LPT);
                for (int k = DT - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
                m_hist[i][0] = m_s2[i];
                all_differ = 1'b1;
                for (int k = 0; k < DT; k++)
                    if (m_hist[i][k] == m_pressed[i]) all_differ = 1'b0;
                m_pe[i] = all_differ && !m_pressed[i];
                m_re[i] = all_differ &&  m_pressed[i];
                if (all_differ) m_pressed[i] = ~m_pressed[i];
            end
            m_s2 = m_s1;
            m_s1 = ~button_pins;
        end
    end

    task automatic test_reset();
        irq_mask = '1;
        @(negedge clk);
        checks++;
        if ({pressed, press_event, release_event, pending, irq} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b required=0", {pressed, press_event, release_event, pending, irq});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({pressed, press_event, release_event, pending, irq} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b required=0", {pressed, press_event, release_event, pending, irq});
        end
        irq_mask = '0;
    endtask

    task automatic test_press_latency();
        button_pins[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if ({pressed[0], press_event[0], pending[0]} !== {k >= 6, k == 6, k >= 7}) begin
                failures++;
                $display("FAIL press_latency k=%0d got pressed/pe/pend=%b%b%b required=%b%b%b",
                         k, pressed[0], press_event[0], pending[0], k >= 6, k == 6, k >= 7);
            end
        end
    endtask

    task automatic test_glitch();
        for (int k = 1; k <= 14; k++) begin
            if (k == 1) button_pins[1] = 1'b0;
            @(negedge clk);
            if (k == 3) button_pins[1] = 1'b1;
            checks++;
            if ({pressed[1], press_event[1], release_event[1], pending[1]} !== 4'b0000) begin
                failures++;
                $display("FAIL glitch k=%0d got=%b required=0000", k,
                         {pressed[1], press_event[1], release_event[1], pending[1]});
            end
        end
    endtask

    task automatic test_simultaneous();
        button_pins[0] = 1'b1;
        repeat (10) @(negedge clk);
        ack = '1;
        @(negedge clk);
        ack = '0;
        @(negedge clk);
        checks++;
        if (pending !== 4'b0000) begin
            failures++;
            $display("FAIL clear_all got=%b required=0000", pending);
        end
        button_pins[0] = 1'b0;
        button_pins[3] = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (press_event !== 4'b1001 || pressed !== 4'b1001) begin
            failures++;
            $display("FAIL simultaneous_press got pe=%b pressed=%b required 1001/1001", press_event, pressed);
        end
        @(negedge clk);
        checks++;
        if (pending !== 4'b1001) begin
            failures++;
            $display("FAIL simultaneous_pending got=%b required=1001", pending);
        end
        ack[0] = 1'b1;
        @(negedge clk);
        ack = '0;
        checks++;
        if (pending !== 4'b1000) begin
            failures++;
            $display("FAIL ack0 got=%b required=1000", pending);
        end
        @(negedge clk);
        checks++;
        if (pending !== 4'b1000) begin
            failures++;
            $display("FAIL ack0_hold got=%b required=1000", pending);
        end
    endtask

    task automatic test_irq_mask();
        // pending is 4'b1000 here; re-set channel 0 to reach 1001
        button_pins[0] = 1'b1;
        repeat (8) @(negedge clk);
        button_pins[0] = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (pending !== 4'b1001) begin
            failures++;
            $display("FAIL irq_setup got=%b required=1001", pending);
        end
        irq_mask = 4'b0010;
        #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_masked got=%b required=0", irq);
        end
        irq_mask = 4'b1000;
        #1;
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_unmasked got=%b required=1", irq);
        end
    endtask

    task automatic test_ack_collision();
        button_pins[2] = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (press_event[2] !== 1'b1) begin
            failures++;
            $display("FAIL collision_pe got=%b required=1", press_event[2]);
        end
        ack[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (pending[2] !== 1'b1) begin
            failures++;
            $display("FAIL collision_set_wins got=%b required=1", pending[2]);
        end
        ack = 4'b0010;
        @(negedge clk);
        checks++;
        if (pending[2:1] !== 2'b10) begin
            failures++;
            $display("FAIL ack_idle got=%b required=10", pending[2:1]);
        end
        ack = 4'b0100;
        @(negedge clk);
        ack = '0;
        checks++;
        if (pending[2] !== 1'b0) begin
            failures++;
            $display("FAIL ack2_clear got=%b required=0", pending[2]);
        end
    endtask

    task automatic test_release();
        button_pins[3] = 1'b1;
        button_pins[2] = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (release_event[3] !== 1'b1 || pressed[3] !== 1'b0 || press_event !== 4'b0000) begin
            failures++;
            $display("FAIL release got re=%b pressed=%b pe=%b required 1/0/0000",
                     release_event[3], pressed[3], press_event);
        end
        @(negedge clk);
        checks++;
        if (pending[3] !== 1'b1 || release_event[3] !== 1'b0) begin
            failures++;
            $display("FAIL release_pending got pend=%b re=%b required 1/0", pending[3], release_event[3]);
        end
    endtask

    task automatic test_reset_mid();
        button_pins = 4'b1101;
        irq_mask    = '1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pressed, press_event, release_event, pending, irq} !== '0) begin
            failures++;
            $display("FAIL reset_async got=%b required=0", {pressed, press_event, release_event, pending, irq});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if ({pressed[1], press_event[1]} !== {k >= 6, k == 6}) begin
                failures++;
                $display("FAIL reset_repress k=%0d got=%b%b required=%b%b",
                         k, pressed[1], press_event[1], k >= 6, k == 6);
            end
        end
    endtask

    task automatic test_random();
        int run_left [CH];
        for (int i = 0; i < CH; i++) run_left[i] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            checks++;
            if ({pressed, press_event, release_event, pending} !== {m_pressed, m_pe, m_re, m_pend}) begin
                failures++;
                $display("FAIL random cyc=%0d got p/pe/re/pend=%b/%b/%b/%b required=%b/%b/%b/%b", cyc,
                         pressed, press_event, release_event, pending, m_pressed, m_pe, m_re, m_pend);
            end
            checks++;
            if (irq !== |(m_pend & irq_mask)) begin
                failures++;
                $display("FAIL random_irq cyc=%0d got=%b required=%b", cyc, irq, |(m_pend & irq_mask));
            end
`ifdef BUTTONS_LONG_PRESS_EN
            checks++;
            if (long_press !== m_lp) begin
                failures++;
                $display("FAIL random_long cyc=%0d got=%b required=%b", cyc, long_press, m_lp);
            end
`endif
            for (int i = 0; i < CH; i++) begin
                if (run_left[i] == 0) begin
                    button_pins[i] = 1'($urandom_range(0, 1));
                    run_left[i]    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40))
                                                                 : int'($urandom_range(1, 8));
                end
                run_left[i]--;
                ack[i] = ($urandom_range(0, 3) == 0);
            end
            irq_mask = 4'($urandom);
        end
        ack = '0;
    endtask

`ifdef BUTTONS_LONG_PRESS_EN
    task automatic test_long_press();
        int rise_k = -1;
        int lp_k   = -1;
        int lp_cnt = 0;
        button_pins = '1;
        repeat (12) @(negedge clk);
        ack = '1;
        @(negedge clk);
        ack = '0;
        button_pins[2] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (pressed[2] && rise_k < 0) rise_k = k;
            if (long_press[2]) begin
                lp_cnt++;
                lp_k = k;
            end
            if (k == 13) begin
                checks++;
                if (pending[2] !== 1'b0) begin
                    failures++;
                    $display("FAIL long_ack_clear got=%b required=0", pending[2]);
                end
            end
            if (k == 8)  ack[2] = 1'b1;
            if (k == 12) ack[2] = 1'b0;
        end
        checks++;
        if (lp_cnt !== 1) begin
            failures++;
            $display("FAIL long_count got=%0d required=1", lp_cnt);
        end
        checks++;
        if (lp_k - rise_k !== LPT) begin
            failures++;
            $display("FAIL long_delay got=%0d required=%0d", lp_k - rise_k, LPT);
        end
        checks++;
        if (pending[2] !== 1'b1) begin
            failures++;
            $display("FAIL long_sets_pending got=%b required=1", pending[2]);
        end
        irq_mask = '1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pressed, press_event, release_event, pending, irq, long_press} !== '0) begin
            failures++;
            $display("FAIL long_reset got=%b required=0",
                     {pressed, press_event, release_event, pending, irq, long_press});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (press_event[2] !== (k == 6)) begin
                failures++;
                $display("FAIL long_repress k=%0d got=%b required=%b", k, press_event[2], k == 6);
            end
        end
    endtask
`endif

    initial begin
        rst_n       = 1'b1;
        button_pins = '1;
        ack         = '0;
        irq_mask    = '0;
        #2 rst_n    = 1'b0;
        test_reset();
        test_press_latency();
        test_glitch();
        test_simultaneous();
        test_irq_mask();
        test_ack_collision();
        test_release();
        test_reset_mid();
        test_random();
`ifdef BUTTONS_LONG_PRESS_EN
        test_long_press();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buttons_event_controller.md
BUTTONS_EVENT_CONTROLLER -- requirements
Module: buttons_event_controller

Interface
REQ-001 Parameter CHANNELS, default 4; number of debounced button channels, legal range 1..32.
REQ-002 Parameter DEBOUNCING_TICKS, default 4; consecutive stable clk cycles needed to accept a level change, minimum 1.
REQ-003 Parameter LONG_PRESS_TICKS, default 1000; hold cycles before a long-press event, minimum 1.
REQ-004 clk  input  1  single system clock; every flop is rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 button_pins  input  CHANNELS  raw, asynchronous, active-low button pins.
REQ-007 ack  input  CHANNELS  per-channel clear of the pending flag, sampled on clk.
REQ-008 irq_mask  input  CHANNELS  per-channel interrupt enable.
REQ-009 pressed  output  CHANNELS  debounced level; 1 = button held.
REQ-010 press_event  output  CHANNELS  one-cycle pulse on a debounced 0->1 transition.
REQ-011 release_event  output  CHANNELS  one-cycle pulse on a debounced 1->0 transition.
REQ-012 pending  output  CHANNELS  sticky flag, set by press_event and cleared by ack.
REQ-013 irq  output  1  OR-reduction of (pending & irq_mask).
REQ-014 long_press  output  CHANNELS  one-cycle long-press pulse; present only under BUTTONS_LONG_PRESS_EN.

Function
REQ-015 Each channel SHALL invert its pin and pass it through a 2-flop synchroniser before any other logic.
REQ-016 Debounce counter, width $clog2(DEBOUNCING_TICKS+1), SHALL behave as follows:
- Cleared in any cycle where the synchronised value equals pressed.
- Otherwise incremented.
- On reaching DEBOUNCING_TICKS, pressed toggles and the counter clears in the same clock edge.
REQ-017 Latency: a clean pin edge SHALL appear on pressed exactly 2+DEBOUNCING_TICKS cycles later.
REQ-018 A glitch shorter than DEBOUNCING_TICKS synchronised cycles SHALL NOT change pressed or produce any event.
REQ-019 press_event and release_event SHALL be registered and asserted in the same cycle pressed changes, for one cycle only.
REQ-020 pending[i] SHALL set the cycle after press_event[i] and clear the cycle after ack[i].
- If set and ack coincide, set wins and pending stays 1.
- ack with pending=0 has no effect.
REQ-021 release_event SHALL NOT affect pending.
REQ-022 irq SHALL be combinational from registered pending and the irq_mask input, with no extra latency.
REQ-023 Channels SHALL be fully independent; simultaneous events on any subset SHALL all be reported in the same cycle.

Reset
REQ-024 While rst_n=0, all of the following SHALL be 0 asynchronously: synchronisers, counters, pressed, press_event, release_event, pending, irq and long_press.
REQ-025 Reset deassertion while a pin is held SHALL produce press_event after 2+DEBOUNCING_TICKS cycles, treated as a new press.
REQ-026 Reset mid-debounce SHALL discard the partial count.

Configuration
REQ-027 Macro BUTTONS_LONG_PRESS_EN SHALL control long-press detection.
- Defined: a per-channel hold counter, width $clog2(LONG_PRESS_TICKS+1), clears when pressed=0 and increments while pressed=1, saturating at LONG_PRESS_TICKS.
- Defined: long_press[i] pulses one cycle when the counter reaches LONG_PRESS_TICKS, at most once per press.
- Defined: long_press also sets pending[i].
- Undefined: the long_press port and hold counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-028 Sub-module button_channel SHALL contain one channel's synchroniser, debounce counter, edge pulses, pending flag and optional hold counter; the top SHALL instantiate CHANNELS copies in a generate loop and form irq.
REQ-029 Package buttons_pkg SHALL hold:
- SYNC_STAGES = 2.
- Default parameter values.
- Function counter_width(n) returning $clog2(n+1).

Verification
REQ-030 Bench parameters: CHANNELS=4, DEBOUNCING_TICKS=4, LONG_PRESS_TICKS=16. Required scenarios:
- Pin0 driven low at cycle 10 and held -> pressed[0]=1 and press_event[0] pulse at cycle 16; pending[0]=1 from cycle 17.
- Pin1 low for 3 cycles, then high -> no change on pressed, press_event, release_event or pending.
- Pins 0 and 3 pressed together, ack[0] at cycle 20 -> both pending set; pending[0] clears at cycle 21; pending[3] stays 1.
- irq_mask=4'b0010 with pending=4'b1001 -> irq=0; setting irq_mask=4'b1000 -> irq=1 in the same cycle.
- ack[2] issued in the same cycle as press_event[2] -> pending[2] remains 1.
- With BUTTONS_LONG_PRESS_EN defined, pin2 held 40 cycles -> exactly one long_press[2] pulse, 16 cycles after pressed[2] rises; rst_n pulsed low mid-hold -> all outputs 0 immediately, and a new press_event occurs 6 cycles after release of reset.
